fifo_sram_stream_adapter: RTL

//  Upstream front-end for the fifoOnSRAM sequencer. Converts a valid/ready
//  16-bit sample stream into that block's active-low start/dataIn protocol
//  and returns each result on a valid/ready output stream.

---
 rtl/fifo_sram_stream_adapter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fifo_sram_stream_adapter.sv
// fifo_sram_stream_adapter: valid/ready stream front-end for the fifoOnSRAM
// sequencer. Drives its active-low start/dataIn handshake, tracks fifoState,
// and returns each result on a valid/ready output stream.
// Optional feature macro: FIFO_ADAPT_PRIME_DROP_EN. When it is defined, the
// first DROP_COUNT completed transactions after reset are discarded.
module fifo_sram_stream_adapter #(
    parameter int unsigned TIMEOUT_CYCLES = 32,
    parameter int unsigned DROP_COUNT     = 12,
    parameter logic [3:0]  ST_SEQ_IDLE    = 4'd0,
    parameter logic [3:0]  ST_SEQ_DONE    = 4'd7
) (
    input  logic        fifoClk,
    input  logic        fifoRst,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    output logic        s_ready,
    output logic        m_valid,
    output logic [15:0] m_data,
    input  logic        m_ready,
    output logic        start,
    output logic [15:0] dataIn,
    input  logic [3:0]  fifoState,
    input  logic [15:0] fifoDataOut,
    output logic [15:0] xferCount,
    output logic        errTimeout
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_DONE = 3'd2;
    localparam logic [2:0] ST_RELEASE   = 3'd3;
    localparam logic [2:0] ST_OUTPUT    = 3'd4;

    localparam int unsigned TCNT_W = 8;
    localparam logic [TCNT_W-1:0] TMO_LIMIT = TCNT_W'(TIMEOUT_CYCLES);

    logic [2:0]        state, state_n;
    logic [TCNT_W-1:0] tcnt, tcnt_n;
    logic              start_n;
    logic [15:0]       data_in_n;
    logic              m_valid_n;
    logic [15:0]       m_data_n;
    logic [15:0]       xfer_n;
    logic              err_n;

`ifdef FIFO_ADAPT_PRIME_DROP_EN
    localparam int unsigned DROP_W = (DROP_COUNT < 2) ? 1 : $clog2(DROP_COUNT + 1);
    logic [DROP_W-1:0] drop_cnt, drop_n;
`else
    localparam int unsigned unused_drop_count = DROP_COUNT;
`endif

    // Accept only when idle; decoded from the state register alone.
    assign s_ready = (state == ST_IDLE);

    // Next-state and next-output decode.
    always_comb begin
        state_n   = state;
        tcnt_n    = tcnt;
        start_n   = start;
        data_in_n = dataIn;
        m_valid_n = m_valid;
        m_data_n  = m_data;
        xfer_n    = xferCount;
        err_n     = errTimeout;
`ifdef FIFO_ADAPT_PRIME_DROP_EN
        drop_n    = drop_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (s_valid) begin
                    data_in_n = s_data;
                    start_n   = 1'b0;
                    tcnt_n    = '0;
                    state_n   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (fifoState != ST_SEQ_IDLE) begin
                    tcnt_n  = '0;
                    state_n = ST_WAIT_DONE;
                end else if (tcnt == TMO_LIMIT) begin
                    err_n   = 1'b1;
                    start_n = 1'b1;
                    tcnt_n  = '0;
                    state_n = ST_IDLE;
                end else begin
                    tcnt_n = tcnt + TCNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (fifoState == ST_SEQ_DONE) begin
                    m_data_n = fifoDataOut;
                    start_n  = 1'b1;
                    xfer_n   = xferCount + 16'd1;
                    tcnt_n   = '0;
                    state_n  = ST_RELEASE;
                end else if (tcnt == TMO_LIMIT) begin
                    err_n   = 1'b1;
                    start_n = 1'b1;
                    tcnt_n  = '0;
                    state_n = ST_IDLE;
                end else begin
                    tcnt_n = tcnt + TCNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (fifoState == ST_SEQ_IDLE) begin
                    tcnt_n = '0;
`ifdef FIFO_ADAPT_PRIME_DROP_EN
                    if (drop_cnt != '0) begin
                        drop_n  = drop_cnt - DROP_W'(1);
                        state_n = ST_IDLE;
                    end else begin
                        m_valid_n = 1'b1;
                        state_n   = ST_OUTPUT;
                    end
`else
                    m_valid_n = 1'b1;
                    state_n   = ST_OUTPUT;
`endif
                end else if (tcnt == TMO_LIMIT) begin
                    err_n   = 1'b1;
                    start_n = 1'b1;
                    tcnt_n  = '0;
                    state_n = ST_IDLE;
                end else begin
                    tcnt_n = tcnt + TCNT_W'(1);
                end
            end
            ST_OUTPUT: begin
                if (m_ready) begin
                    m_valid_n = 1'b0;
                    state_n   = ST_IDLE;
                end
            end
            default: begin
                start_n = 1'b1;
                tcnt_n  = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset forces start high immediately.
    always_ff @(posedge fifoClk or posedge fifoRst) begin
        if (fifoRst) begin
            state      <= ST_IDLE;
            tcnt       <= '0;
            start      <= 1'b1;
            dataIn     <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            xferCount  <= '0;
            errTimeout <= 1'b0;
`ifdef FIFO_ADAPT_PRIME_DROP_EN
            drop_cnt   <= DROP_W'(DROP_COUNT);
`endif
        end else begin
            state      <= state_n;
            tcnt       <= tcnt_n;
            start      <= start_n;
            dataIn     <= data_in_n;
            m_valid    <= m_valid_n;
            m_data     <= m_data_n;
            xferCount  <= xfer_n;
            errTimeout <= err_n;
`ifdef FIFO_ADAPT_PRIME_DROP_EN
            drop_cnt   <= drop_n;
`endif
        end
    end

endmodule
